// File: rtl/exec_ctrl_stage.sv
// Execute-stage control pipeline register with conditional-execution and flag register.
// Controls are registered from D to E (1 cycle); gated outputs and CondExE are combinational from E state.
// StallE holds the stage and defers flag writes; FlushE injects a bubble but still retires E's flag write.
module exec_ctrl_stage (
    input  logic       clk,
    input  logic       reset,
    input  logic       StallE,
    input  logic       FlushE,
    input  logic       PCSrcD,
    input  logic       RegWriteD,
    input  logic       MemtoRegD,
    input  logic       MemWriteD,
    input  logic       BranchD,
    input  logic       ALUSrcD,
    input  logic [1:0] ALUControlD,
    input  logic [1:0] FlagWriteD,
    input  logic [3:0] CondD,
    input  logic [3:0] ALUFlagsE,
    output logic       PCSrcE,
    output logic       RegWriteE,
    output logic       MemWriteE,
    output logic       BranchTakenE,
    output logic       MemtoRegE,
    output logic       ALUSrcE,
    output logic [1:0] ALUControlE,
    output logic       CondExE,
    output logic [3:0] FlagsE
);

    typedef struct packed {
        logic       pc_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic [1:0] alu_control;
        logic [1:0] flag_write;
        logic [3:0] cond;
    } ctrl_t;

    // A bubble executes unconditionally (AL) so it never suppresses anything by accident.
    localparam ctrl_t BUBBLE = '{
        pc_src:      1'b0,
        reg_write:   1'b0,
        mem_to_reg:  1'b0,
        mem_write:   1'b0,
        branch:      1'b0,
        alu_src:     1'b0,
        alu_control: 2'b00,
        flag_write:  2'b00,
        cond:        4'b1110
    };

    ctrl_t ctrl_d;
    ctrl_t ctrl_e;
    logic  [3:0] flags;
    logic  cond_ex;
    logic  flag_n;
    logic  flag_z;
    logic  flag_c;
    logic  flag_v;

    always_comb begin
        ctrl_d.pc_src      = PCSrcD;
        ctrl_d.reg_write   = RegWriteD;
        ctrl_d.mem_to_reg  = MemtoRegD;
        ctrl_d.mem_write   = MemWriteD;
        ctrl_d.branch      = BranchD;
        ctrl_d.alu_src     = ALUSrcD;
        ctrl_d.alu_control = ALUControlD;
        ctrl_d.flag_write  = FlagWriteD;
        ctrl_d.cond        = CondD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_e <= BUBBLE;
        end else if (FlushE) begin
            ctrl_e <= BUBBLE;
        end else if (!StallE) begin
            ctrl_e <= ctrl_d;
        end
    end

    assign flag_n = flags[3];
    assign flag_z = flags[2];
    assign flag_c = flags[1];
    assign flag_v = flags[0];

    always_comb begin
        cond_ex = 1'b0;
        case (ctrl_e.cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = !flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = !flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = !flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = !flag_v;
            4'b1000: cond_ex = flag_c && !flag_z;
            4'b1001: cond_ex = !flag_c || flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = !flag_z && (flag_n == flag_v);
            4'b1101: cond_ex = flag_z || (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Flag write is tied to the edge on which E advances, so a stalled instruction writes once.
    // FlushE does not block it: the flush replaces the next instruction, not the one in E.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (!StallE && cond_ex) begin
            if (ctrl_e.flag_write[1]) begin
                flags[3:2] <= ALUFlagsE[3:2];
            end
            if (ctrl_e.flag_write[0]) begin
                flags[1:0] <= ALUFlagsE[1:0];
            end
        end
    end

    assign CondExE      = cond_ex;
    assign PCSrcE       = ctrl_e.pc_src    & cond_ex;
    assign RegWriteE    = ctrl_e.reg_write & cond_ex;
    assign MemWriteE    = ctrl_e.mem_write & cond_ex;
    assign BranchTakenE = ctrl_e.branch    & cond_ex;
    assign MemtoRegE    = ctrl_e.mem_to_reg;
    assign ALUSrcE      = ctrl_e.alu_src;
    assign ALUControlE  = ctrl_e.alu_control;
    assign FlagsE       = flags;

endmodule

// File: tb/tb_exec_ctrl_stage.sv
// Directed vectors for exec_ctrl_stage plus a full condition-code sweep against a reference table.
module tb_exec_ctrl_stage;

    logic       clk;
    logic       reset;
    logic       StallE;
    logic       FlushE;
    logic       PCSrcD;
    logic       RegWriteD;
    logic       MemtoRegD;
    logic       MemWriteD;
    logic       BranchD;
    logic       ALUSrcD;
    logic [1:0] ALUControlD;
    logic [1:0] FlagWriteD;
    logic [3:0] CondD;
    logic [3:0] ALUFlagsE;
    logic       PCSrcE;
    logic       RegWriteE;
    logic       MemWriteE;
    logic       BranchTakenE;
    logic       MemtoRegE;
    logic       ALUSrcE;
    logic [1:0] ALUControlE;
    logic       CondExE;
    logic [3:0] FlagsE;

    int checks = 0;
    int errors = 0;

    exec_ctrl_stage dut (
        .clk          (clk),
        .reset        (reset),
        .StallE       (StallE),
        .FlushE       (FlushE),
        .PCSrcD       (PCSrcD),
        .RegWriteD    (RegWriteD),
        .MemtoRegD    (MemtoRegD),
        .MemWriteD    (MemWriteD),
        .BranchD      (BranchD),
        .ALUSrcD      (ALUSrcD),
        .ALUControlD  (ALUControlD),
        .FlagWriteD   (FlagWriteD),
        .CondD        (CondD),
        .ALUFlagsE    (ALUFlagsE),
        .PCSrcE       (PCSrcE),
        .RegWriteE    (RegWriteE),
        .MemWriteE    (MemWriteE),
        .BranchTakenE (BranchTakenE),
        .MemtoRegE    (MemtoRegE),
        .ALUSrcE      (ALUSrcE),
        .ALUControlE  (ALUControlE),
        .CondExE      (CondExE),
        .FlagsE       (FlagsE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl = {pcsrc, regwrite, memtoreg, memwrite, branch, alusrc}
    // expected = {PCSrcE, RegWriteE, MemWriteE, BranchTakenE, MemtoRegE, ALUSrcE, ALUControlE, CondExE, FlagsE}
    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic [5:0]  ctl;
        logic [1:0]  aluc;
        logic [1:0]  fw;
        logic [3:0]  cond;
        logic [3:0]  af;
        logic [12:0] expected;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cf & !z;
            4'd9:  return !cf | z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z & (n == v);
            4'd13: return z | (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input logic rst, input logic stall, input logic flush, input logic [5:0] ctl,
                         input logic [1:0] aluc, input logic [1:0] fw, input logic [3:0] cond,
                         input logic [3:0] af);
        reset       = rst;
        StallE      = stall;
        FlushE      = flush;
        PCSrcD      = ctl[5];
        RegWriteD   = ctl[4];
        MemtoRegD   = ctl[3];
        MemWriteD   = ctl[2];
        BranchD     = ctl[1];
        ALUSrcD     = ctl[0];
        ALUControlD = aluc;
        FlagWriteD  = fw;
        CondD       = cond;
        ALUFlagsE   = af;
    endtask

    function automatic logic [12:0] outputs_now();
        return {PCSrcE, RegWriteE, MemWriteE, BranchTakenE, MemtoRegE, ALUSrcE,
                ALUControlE, CondExE, FlagsE};
    endfunction

    initial begin
        logic [12:0] got;
        logic        exp_cx;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 6'b111111, 2'b11, 2'b11, 4'b0000, 4'b1111, 13'b0000_00_00_1_0000};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 6'b011001, 2'b10, 2'b10, 4'b1110, 4'b1111, 13'b0100_11_10_1_0000};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 6'b000000, 2'b00, 2'b01, 4'b1110, 4'b1111, 13'b0000_00_00_1_1100};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 6'b000000, 2'b00, 2'b00, 4'b1110, 4'b1111, 13'b0000_00_00_1_1111};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 6'b000000, 2'b00, 2'b11, 4'b1110, 4'b0000, 13'b0000_00_00_1_1111};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 6'b010000, 2'b00, 2'b00, 4'b0000, 4'b0100, 13'b0100_00_00_1_0100};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 6'b010000, 2'b00, 2'b00, 4'b0001, 4'b1111, 13'b0000_00_00_0_0100};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 6'b000000, 2'b00, 2'b11, 4'b1110, 4'b1111, 13'b0000_00_00_1_0100};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 6'b100000, 2'b00, 2'b11, 4'b0000, 4'b0000, 13'b0000_00_00_0_0000};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 6'b000000, 2'b00, 2'b00, 4'b1110, 4'b0100, 13'b0000_00_00_1_0000};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 6'b000110, 2'b00, 2'b00, 4'b1111, 4'b0000, 13'b0000_00_00_0_0000};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 6'b100110, 2'b00, 2'b00, 4'b1110, 4'b0000, 13'b1011_00_00_1_0000};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 6'b010000, 2'b00, 2'b11, 4'b1110, 4'b1010, 13'b0100_00_00_1_0000};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 6'b000000, 2'b00, 2'b00, 4'b0000, 4'b1010, 13'b0100_00_00_1_0000};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 6'b000000, 2'b00, 2'b00, 4'b0000, 4'b1010, 13'b0100_00_00_1_0000};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 6'b000000, 2'b00, 2'b00, 4'b1110, 4'b1010, 13'b0000_00_00_1_1010};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 6'b000000, 2'b00, 2'b00, 4'b1110, 4'b0101, 13'b0000_00_00_1_1010};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 6'b011101, 2'b11, 2'b11, 4'b0001, 4'b0000, 13'b0110_11_11_1_1010};
        vecs[18] = '{1'b0, 1'b1, 1'b1, 6'b010000, 2'b00, 2'b00, 4'b0000, 4'b0000, 13'b0000_00_00_1_1010};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 6'b000000, 2'b00, 2'b11, 4'b1110, 4'b1111, 13'b0000_00_00_1_1010};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 6'b010000, 2'b00, 2'b00, 4'b1110, 4'b0110, 13'b0000_00_00_1_0110};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 6'b010000, 2'b00, 2'b11, 4'b1110, 4'b0000, 13'b0100_00_00_1_0110};
        vecs[22] = '{1'b1, 1'b1, 1'b0, 6'b111111, 2'b11, 2'b11, 4'b0000, 4'b1111, 13'b0000_00_00_1_0000};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 6'b010000, 2'b00, 2'b11, 4'b1110, 4'b0000, 13'b0100_00_00_1_0000};
        vecs[24] = '{1'b1, 1'b0, 1'b1, 6'b111111, 2'b11, 2'b11, 4'b0000, 4'b1111, 13'b0000_00_00_1_0000};

        drive(1'b1, 1'b0, 1'b0, 6'b000000, 2'b00, 2'b00, 4'b1110, 4'b0000);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].ctl,
                  vecs[i].aluc, vecs[i].fw, vecs[i].cond, vecs[i].af);
            @(posedge clk);
            #1;
            got = outputs_now();
            checks++;
            if (got !== vecs[i].expected) begin
                errors++;
                $display("FAIL vec%0d outputs got %b expected %b", i, got, vecs[i].expected);
            end
        end

        // Sweep every condition code against every flag pattern.
        for (int p = 0; p < 16; p++) begin
            drive(1'b0, 1'b0, 1'b0, 6'b000000, 2'b00, 2'b11, 4'b1110, p[3:0]);
            @(posedge clk);
            #1;
            drive(1'b0, 1'b0, 1'b0, 6'b000000, 2'b00, 2'b00, 4'b1110, p[3:0]);
            @(posedge clk);
            #1;
            checks++;
            if (FlagsE !== p[3:0]) begin
                errors++;
                $display("FAIL sweep_flags pattern %0d got %b expected %b", p, FlagsE, p[3:0]);
            end
            for (int c = 0; c < 16; c++) begin
                drive(1'b0, 1'b0, 1'b0, 6'b010000, 2'b00, 2'b00, c[3:0], ~p[3:0]);
                @(posedge clk);
                #1;
                exp_cx = ref_cond(c[3:0], p[3:0]);
                checks++;
                if (CondExE !== exp_cx || RegWriteE !== exp_cx) begin
                    errors++;
                    $display("FAIL sweep cond %b flags %b got condex=%b regwrite=%b expected %b",
                             c[3:0], p[3:0], CondExE, RegWriteE, exp_cx);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
